// File: rtl/alu_arbiter.sv
// Round-robin front end that shares one combinational ALU between two requesters.
// One operation is in flight at a time; each requester's result is parked until consumed.

module alu_arb_rsp #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wr,
  input  logic [XLEN-1:0] wdata,
  input  logic            rd,
  output logic            valid,
  output logic [XLEN-1:0] res
);
  // A write and a consume never coincide: the slot was empty when its op was granted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      res   <= '0;
    end else if (wr) begin
      valid <= 1'b1;
      res   <= wdata;
    end else if (rd) begin
      valid <= 1'b0;
    end
  end
endmodule

module alu_arbiter #(
  parameter int XLEN = 32,
  parameter int CW   = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [CW-1:0]   req0_code,
  input  logic [XLEN-1:0] req0_op1,
  input  logic [XLEN-1:0] req0_op2,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [CW-1:0]   req1_code,
  input  logic [XLEN-1:0] req1_op1,
  input  logic [XLEN-1:0] req1_op2,
  output logic            rsp0_valid,
  input  logic            rsp0_ready,
  output logic [XLEN-1:0] rsp0_res,
  output logic            rsp1_valid,
  input  logic            rsp1_ready,
  output logic [XLEN-1:0] rsp1_res,
  output logic [CW-1:0]   alu_code,
  output logic [XLEN-1:0] alu_op1,
  output logic [XLEN-1:0] alu_op2,
  input  logic [XLEN-1:0] alu_res,
  output logic [15:0]     ops_done
);
  localparam logic [CW-1:0] OP_NONE = '0;

  typedef enum logic {IDLE, EXEC} state_t;
  state_t state_q, state_d;

  logic [1:0]            req_valid, req_ready, rsp_valid, rsp_ready, elig, rsp_wr;
  logic [1:0][CW-1:0]    req_code;
  logic [1:0][XLEN-1:0]  req_op1, req_op2, rsp_res;
  logic                  last_q, gnt_id, hs, id_q;
  logic [CW-1:0]         code_q;
  logic [XLEN-1:0]       op1_q, op2_q;
  logic [15:0]           ops_q;

  assign req_valid = {req1_valid, req0_valid};
  assign req_code  = {req1_code, req0_code};
  assign req_op1   = {req1_op1, req0_op1};
  assign req_op2   = {req1_op2, req0_op2};
  assign rsp_ready = {rsp1_ready, rsp0_ready};

  // A requester still holding an unconsumed result sits out arbitration.
  assign elig   = req_valid & ~rsp_valid;
  assign gnt_id = (&elig) ? ~last_q : elig[1];

  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    hs        = 1'b0;
    unique case (state_q)
      IDLE: if (|elig) begin
        req_ready[gnt_id] = rst_n;
        hs                = 1'b1;
        state_d           = EXEC;
      end
      EXEC: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      id_q    <= 1'b0;
      code_q  <= OP_NONE;
      op1_q   <= '0;
      op2_q   <= '0;
      ops_q   <= '0;
    end else begin
      state_q <= state_d;
      if (hs) begin
        last_q <= gnt_id;
        id_q   <= gnt_id;
        code_q <= req_code[gnt_id];
        op1_q  <= req_op1[gnt_id];
        op2_q  <= req_op2[gnt_id];
      end
      if (state_q == EXEC) ops_q <= ops_q + 16'd1;
    end
  end

  assign rsp_wr   = (state_q == EXEC) ? (2'b01 << id_q) : 2'b00;
  assign alu_code = (state_q == EXEC) ? code_q : OP_NONE;
  assign alu_op1  = (state_q == EXEC) ? op1_q : '0;
  assign alu_op2  = (state_q == EXEC) ? op2_q : '0;

  for (genvar k = 0; k < 2; k++) begin : g_rsp
    alu_arb_rsp #(.XLEN(XLEN)) u_rsp (
      .clk   (clk),
      .rst_n (rst_n),
      .wr    (rsp_wr[k]),
      .wdata (alu_res),
      .rd    (rsp_ready[k]),
      .valid (rsp_valid[k]),
      .res   (rsp_res[k])
    );
  end

  assign req0_ready = req_ready[0];
  assign req1_ready = req_ready[1];
  assign rsp0_valid = rsp_valid[0];
  assign rsp1_valid = rsp_valid[1];
  assign rsp0_res   = rsp_res[0];
  assign rsp1_res   = rsp_res[1];
  assign ops_done   = ops_q;
endmodule
